// File: rtl/array_mul_sig_if.sv
// rtl/array_mul_sig_if.sv - operand/product bundle for the significand multiplier
interface array_mul_sig_if #(
  parameter int WIDTH = 10
);
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               azero;
  logic               bzero;
  logic [2*WIDTH+3:0] s;

  modport master (output a, output b, output azero, output bzero, input s);
  modport slave  (input a, input b, input azero, input bzero, output s);
endinterface

// File: rtl/array_mul_sig.sv
// rtl/array_mul_sig.sv - two-stage unsigned ripple-array significand multiplier
// Restores implicit bits, multiplies with an AND/full-adder array, registers in and out.
module array_mul_sig #(
  parameter int WIDTH = 10
) (
  input logic             CLK,
  input logic             RST,
  array_mul_sig_if.slave  bus
);
  localparam int M     = WIDTH + 1;
  localparam int PW    = 2 * M;
  localparam int OUT_W = 2 * WIDTH + 4;

  // Stage 1 holds the restored significands; a cleared register is a zero
  // operand, so the cycle right after reset still yields s = 0.
  logic [M-1:0] ma_r;
  logic [M-1:0] mb_r;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ma_r <= '0;
      mb_r <= '0;
    end else begin
      ma_r <= {~bus.azero, bus.a};
      mb_r <= {~bus.bzero, bus.b};
    end
  end

  logic [M:0]    acc;
  logic [M:0]    nxt;
  logic          carry;
  logic          x;
  logic          y;
  logic [PW-1:0] p;

  // Each row adds the next partial product to the upper bits of the running
  // sum through a ripple of full adders; the LSB of each row retires into p.
  always_comb begin
    acc   = '0;
    nxt   = '0;
    carry = 1'b0;
    x     = 1'b0;
    y     = 1'b0;
    p     = '0;
    for (int j = 0; j < M; j++) begin
      acc[j] = ma_r[j] & mb_r[0];
    end
    p[0] = acc[0];
    for (int i = 1; i < M; i++) begin
      carry = 1'b0;
      for (int j = 0; j < M; j++) begin
        x      = acc[j+1];
        y      = ma_r[j] & mb_r[i];
        nxt[j] = x ^ y ^ carry;
        carry  = (x & y) | (carry & (x ^ y));
      end
      nxt[M] = carry;
      acc    = nxt;
      p[i]   = acc[0];
    end
    p[PW-1:M] = acc[M:1];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bus.s <= '0;
    end else begin
      bus.s <= {{(OUT_W-PW){1'b0}}, p};
    end
  end
endmodule

// File: tb/tb_array_mul_sig.sv
// tb/tb_array_mul_sig.sv - self-checking bench for array_mul_sig
module tb_array_mul_sig;
  logic CLK = 1'b0;
  logic RST = 1'b1;

  array_mul_sig_if bus ();

  array_mul_sig dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  logic [23:0] q[$];

  function automatic logic [23:0] model(input logic [9:0] a, input logic [9:0] b,
                                        input logic az, input logic bz);
    int unsigned ma;
    int unsigned mb;
    ma = (az ? 0 : 1024) + a;
    mb = (bz ? 0 : 1024) + b;
    return 24'(ma * mb);
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: s=%h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Products of every captured pair, oldest first; s shows the one two edges back.
  always @(posedge CLK or posedge RST) begin
    if (RST) q.delete();
    else     q.push_back(model(bus.a, bus.b, bus.azero, bus.bzero));
  end

  always @(negedge CLK) begin
    if (RST) check("reset_hold", bus.s, 24'h0);
    else     check("model", bus.s, (q.size() >= 2) ? q[q.size()-2] : 24'h0);
  end

  task automatic drive(input logic [9:0] a, input logic [9:0] b, input logic az, input logic bz);
    bus.a     = a;
    bus.b     = b;
    bus.azero = az;
    bus.bzero = bz;
  endtask

  task automatic lit(input string name, input logic [9:0] a, input logic [9:0] b,
                     input logic az, input logic bz, input logic [23:0] exp);
    drive(a, b, az, bz);
    repeat (2) @(negedge CLK);
    check(name, bus.s, exp);
  endtask

  task automatic async_pulse(input string name);
    @(posedge CLK);
    #2 RST = 1'b1;
    #1 check(name, bus.s, 24'h0);
    @(negedge CLK);
    RST = 1'b0;
  endtask

  initial begin
    drive(10'h155, 10'h2AA, 1'b0, 1'b0);
    repeat (3) @(negedge CLK);
    check("reset_initial", bus.s, 24'h0);
    RST = 1'b0;

    lit("zero_frac", 10'h000, 10'h000, 1'b0, 1'b0, 24'h100000);
    lit("max_prod",  10'h3FF, 10'h3FF, 1'b0, 1'b0, 24'h3FF001);
    async_pulse("async_reset_max");
    lit("denorm_5x10", 10'd5, 10'd10, 1'b1, 1'b1, 24'h000032);
    lit("zero_a",      10'h000, 10'h3FF, 1'b1, 1'b0, 24'h000000);
    lit("zero_b",      10'h2AB, 10'h000, 1'b0, 1'b1, 24'h000000);
    lit("norm_one",    10'h000, 10'h200, 1'b0, 1'b0, 24'h180000);

    for (int k = 1; k <= 10; k++) begin
      if (k >= 3) check("b2b", bus.s, 24'((k - 2) * (2 * (k - 2))));
      if (k <= 8) drive(10'(k), 10'(2 * k), 1'b1, 1'b1);
      @(negedge CLK);
    end

    for (int i = 0; i < 250; i++) begin
      drive(10'(i), 10'(2 * i), i[0], i[1]);
      if (i == 125) async_pulse("async_reset_sweep");
      else repeat (2) @(negedge CLK);
    end

    repeat (3) @(negedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
